// File: rtl/output_port_allocator_pkg.sv
// -----------------------------------------------------------------------------
// output_port_allocator_pkg
// Shared definitions for the mesh-router output-port allocator: flit-type
// codes, the allocator FSM state type, the width of the input-select index
// and a helper that recognises packet-ending flits.
// No ports (package).
// -----------------------------------------------------------------------------
package output_port_allocator_pkg;

   localparam int SEL_W = 3;

   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_BODY   = 3'b010;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;
   localparam logic [2:0] FLIT_SINGLE = 3'b101;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } alloc_state_t;

   // TAIL and SINGLE both carry bit 2, which is what closes a packet.
   function automatic logic is_last_flit(input logic [2:0] ft);
      return ft[2];
   endfunction

endpackage

// File: rtl/output_port_allocator_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans requesters starting one position
// after the last served index and wrapping modulo NUM_IN, so the last served
// input always has the lowest priority.
// Ports:
//   req          in   NUM_IN  request vector
//   last_served  in   IDX_W   index of the most recently granted input
//   valid        out  1       at least one request present
//   pick_oh      out  NUM_IN  one-hot winner (0 when no request)
//   pick_idx     out  IDX_W   binary winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_pick
   import output_port_allocator_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int IDX_W  = SEL_W
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [IDX_W-1:0]  last_served,
   output logic              valid,
   output logic [NUM_IN-1:0] pick_oh,
   output logic [IDX_W-1:0]  pick_idx
);

   // Walk the candidates in priority order; the first requester found wins.
   always_comb begin
      int cand;
      cand     = 0;
      valid    = 1'b0;
      pick_oh  = '0;
      pick_idx = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = (int'(last_served) + k) % NUM_IN;
         if (!valid && req[cand]) begin
            valid         = 1'b1;
            pick_oh[cand] = 1'b1;
            pick_idx      = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// -----------------------------------------------------------------------------
// output_port_allocator
// Shares one router output port among NUM_IN input buffers. A round-robin
// pick is locked in wormhole-style until the packet's last flit moves, and
// every flit transfer is gated by a credit counter mirroring the free slots
// of the downstream input buffer.
// Ports:
//   clk         in   1          clock, all state on rising edge
//   rst         in   1          asynchronous active-low reset
//   req         in   NUM_IN     input i head flit is routed here
//   flit_type   in   3*NUM_IN   flit type of input i in bits [3i+2:3i]
//   credit_in   in   1          downstream freed one slot (1-cycle pulse)
//   grant       out  NUM_IN     registered one-hot grant (crossbar select)
//   sel         out  3          binary index of granted input, 0 when idle
//   xfer        out  1          combinational: a flit moves this cycle
//   idle        out  1          no input granted
//   credit_cnt  out  CNT_W      downstream free-slot count
//   credit_err  out  1          sticky: credit returned while already full
// -----------------------------------------------------------------------------
module output_port_allocator
   import output_port_allocator_pkg::*;
#(
   parameter int NUM_IN       = 5,
   parameter int CREDIT_DEPTH = 4,
   parameter int CNT_W        = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IN-1:0]   req,
   input  logic [3*NUM_IN-1:0] flit_type,
   input  logic                credit_in,
   output logic [NUM_IN-1:0]   grant,
   output logic [SEL_W-1:0]    sel,
   output logic                xfer,
   output logic                idle,
   output logic [CNT_W-1:0]    credit_cnt,
   output logic                credit_err
);

   localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(CREDIT_DEPTH);

   alloc_state_t      state_q, state_d;
   logic [NUM_IN-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  last_served_q, last_served_d;
   logic              idle_q, idle_d;
   logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
   logic              credit_err_q, credit_err_d;

   logic              pick_valid;
   logic [NUM_IN-1:0] pick_oh;
   logic [SEL_W-1:0]  pick_idx;
   logic [2:0]        granted_type;

   rr_pick #(
      .NUM_IN (NUM_IN),
      .IDX_W  (SEL_W)
   ) u_rr_pick (
      .req         (req),
      .last_served (last_served_q),
      .valid       (pick_valid),
      .pick_oh     (pick_oh),
      .pick_idx    (pick_idx)
   );

   // Flit type of the granted input; the one-hot grant acts as the mux select.
   always_comb begin
      granted_type = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_q[i]) begin
            granted_type = granted_type | flit_type[3*i +: 3];
         end
      end
   end

   // Only the locked owner can move a flit, and only while a credit is free.
   assign xfer = (state_q == ST_LOCKED) && (|(req & grant_q)) && (credit_cnt_q != '0);

   // Arbitration happens only in IDLE; once locked, the grant is held until
   // the packet-ending flit actually transfers, even if the owner drops req.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      sel_d         = sel_q;
      last_served_d = last_served_q;
      idle_d        = idle_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d       = ST_LOCKED;
               grant_d       = pick_oh;
               sel_d         = pick_idx;
               last_served_d = pick_idx;
               idle_d        = 1'b0;
            end
         end
         ST_LOCKED: begin
            if (xfer && is_last_flit(granted_type)) begin
               state_d = ST_IDLE;
               grant_d = '0;
               sel_d   = '0;
               idle_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            sel_d   = '0;
            idle_d  = 1'b1;
         end
      endcase
   end

   // A simultaneous transfer and returned credit cancel out. A credit
   // returned while already full is an upstream bookkeeping error: the count
   // saturates and the error flag latches until reset.
   always_comb begin
      credit_cnt_d = credit_cnt_q;
      credit_err_d = credit_err_q;
      case ({xfer, credit_in})
         2'b10: credit_cnt_d = credit_cnt_q - CNT_W'(1);
         2'b01: begin
            if (credit_cnt_q == CREDIT_FULL) begin
               credit_err_d = 1'b1;
            end else begin
               credit_cnt_d = credit_cnt_q + CNT_W'(1);
            end
         end
         default: credit_cnt_d = credit_cnt_q;
      endcase
   end

   // Last served starts at NUM_IN-1 so input 0 has top priority after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         sel_q         <= '0;
         last_served_q <= SEL_W'(NUM_IN - 1);
         idle_q        <= 1'b1;
         credit_cnt_q  <= CREDIT_FULL;
         credit_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         sel_q         <= sel_d;
         last_served_q <= last_served_d;
         idle_q        <= idle_d;
         credit_cnt_q  <= credit_cnt_d;
         credit_err_q  <= credit_err_d;
      end
   end

   assign grant      = grant_q;
   assign sel        = sel_q;
   assign idle       = idle_q;
   assign credit_cnt = credit_cnt_q;
   assign credit_err = credit_err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// -----------------------------------------------------------------------------
// tb_output_port_allocator
// Directed-vector bench for output_port_allocator. Stimulus pushes the grant
// and flit-transfer events it expects; a monitor sampling on the falling edge
// pops and compares them as the design presents them. Status outputs are
// checked directly between vectors.
// -----------------------------------------------------------------------------
module tb_output_port_allocator;
   import output_port_allocator_pkg::*;

   localparam int NUM_IN       = 5;
   localparam int CREDIT_DEPTH = 4;
   localparam int CNT_W        = 3;

   localparam logic [2:0] H = FLIT_HEADER;
   localparam logic [2:0] B = FLIT_BODY;
   localparam logic [2:0] T = FLIT_TAIL;
   localparam logic [2:0] S = FLIT_SINGLE;

   logic                clk;
   logic                rst;
   logic [NUM_IN-1:0]   req;
   logic [3*NUM_IN-1:0] flit_type;
   logic                credit_in;
   logic [NUM_IN-1:0]   grant;
   logic [SEL_W-1:0]    sel;
   logic                xfer;
   logic                idle;
   logic [CNT_W-1:0]    credit_cnt;
   logic                credit_err;

   int num_checks = 0;
   int num_fails  = 0;

   logic [8:0] grant_exp_q[$];
   logic [5:0] xfer_exp_q[$];

   output_port_allocator #(
      .NUM_IN       (NUM_IN),
      .CREDIT_DEPTH (CREDIT_DEPTH),
      .CNT_W        (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .flit_type  (flit_type),
      .credit_in  (credit_in),
      .grant      (grant),
      .sel        (sel),
      .xfer       (xfer),
      .idle       (idle),
      .credit_cnt (credit_cnt),
      .credit_err (credit_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [14:0] packTypes(input logic [2:0] t4, input logic [2:0] t3,
                                             input logic [2:0] t2, input logic [2:0] t1,
                                             input logic [2:0] t0);
      return {t4, t3, t2, t1, t0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Holds the given inputs for one clock cycle, returning just after the edge.
   task automatic applyStimulus(input logic [4:0] r, input logic [14:0] ft, input logic cin);
      req       = r;
      flit_type = ft;
      credit_in = cin;
      @(posedge clk);
      #1;
   endtask

   task automatic expectGrant(input logic [4:0] g, input logic [2:0] s);
      grant_exp_q.push_back({g, s, 1'b0});
   endtask

   task automatic expectXfer(input logic [2:0] s, input logic [2:0] t);
      xfer_exp_q.push_back({s, t});
   endtask

   // Monitor: every newly asserted grant and every transfer must match the
   // next expected event of its kind.
   initial begin
      logic [4:0] prev_grant;
      logic [8:0] exp_g;
      logic [5:0] exp_x;
      logic [2:0] act_type;
      prev_grant = '0;
      forever begin
         @(negedge clk);
         if (grant !== prev_grant && grant !== '0) begin
            if (grant_exp_q.size() == 0) begin
               num_checks++;
               num_fails++;
               $display("[TB] FAIL unexpected_grant: got grant=%b sel=%0d, expected none at %0t", grant, sel, $time);
            end else begin
               exp_g = grant_exp_q.pop_front();
               checkOutput("grant_event {grant,sel,idle}", {23'd0, grant, sel, idle}, {23'd0, exp_g});
            end
         end
         prev_grant = grant;
         if (xfer === 1'b1) begin
            act_type = flit_type[3*sel +: 3];
            if (xfer_exp_q.size() == 0) begin
               num_checks++;
               num_fails++;
               $display("[TB] FAIL unexpected_xfer: got sel=%0d type=%b, expected none at %0t", sel, act_type, $time);
            end else begin
               exp_x = xfer_exp_q.pop_front();
               checkOutput("xfer_event {sel,type}", {26'd0, sel, act_type}, {26'd0, exp_x});
            end
         end
      end
   end

   initial begin
      logic [14:0] all_s;
      logic [14:0] t2_pkt;
      all_s     = packTypes(S, S, S, S, S);
      req       = '0;
      flit_type = all_s;
      credit_in = 1'b0;
      rst       = 1'b1;
      #1 rst    = 1'b0;

      // Reset state
      @(negedge clk);
      checkOutput("reset_grant", 32'(grant), 32'd0);
      checkOutput("reset_sel", 32'(sel), 32'd0);
      checkOutput("reset_idle", 32'(idle), 32'd1);
      checkOutput("reset_credit_cnt", 32'(credit_cnt), 32'd4);
      checkOutput("reset_credit_err", 32'(credit_err), 32'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Round robin over inputs 1, 2, 4 with single-flit packets
      $display("[TB] round-robin order");
      expectGrant(5'b00010, 3'd1); expectXfer(3'd1, S);
      expectGrant(5'b00100, 3'd2); expectXfer(3'd2, S);
      expectGrant(5'b10000, 3'd4); expectXfer(3'd4, S);
      repeat (6) applyStimulus(5'b10110, all_s, 1'b0);
      applyStimulus(5'b00000, all_s, 1'b0);
      checkOutput("rr_idle_after", 32'(idle), 32'd1);
      checkOutput("rr_credit_after", 32'(credit_cnt), 32'd1);
      repeat (3) applyStimulus(5'b00000, all_s, 1'b1);
      checkOutput("rr_credit_restored", 32'(credit_cnt), 32'd4);

      // Wormhole packet on input 3 while input 0 keeps requesting
      $display("[TB] wormhole lock");
      expectGrant(5'b01000, 3'd3);
      expectXfer(3'd3, H); expectXfer(3'd3, B); expectXfer(3'd3, B); expectXfer(3'd3, T);
      expectGrant(5'b00001, 3'd0); expectXfer(3'd0, S);
      applyStimulus(5'b01000, packTypes(H, H, H, H, S), 1'b0);
      applyStimulus(5'b01001, packTypes(H, H, H, H, S), 1'b0);
      applyStimulus(5'b01001, packTypes(H, B, H, H, S), 1'b0);
      checkOutput("wh_credit_before_same_cycle", 32'(credit_cnt), 32'd2);
      applyStimulus(5'b01001, packTypes(H, B, H, H, S), 1'b1);
      checkOutput("wh_credit_same_cycle", 32'(credit_cnt), 32'd2);
      applyStimulus(5'b01001, packTypes(H, T, H, H, S), 1'b0);
      checkOutput("wh_idle_after_tail", 32'(idle), 32'd1);
      checkOutput("wh_grant_after_tail", 32'(grant), 32'd0);
      applyStimulus(5'b00001, packTypes(H, H, H, H, S), 1'b0);
      applyStimulus(5'b00001, packTypes(H, H, H, H, S), 1'b0);
      applyStimulus(5'b00000, packTypes(H, H, H, H, S), 1'b0);
      checkOutput("wh_credit_empty", 32'(credit_cnt), 32'd0);
      repeat (4) applyStimulus(5'b00000, all_s, 1'b1);
      checkOutput("wh_credit_restored", 32'(credit_cnt), 32'd4);
      checkOutput("wh_credit_err_clear", 32'(credit_err), 32'd0);

      // Credit starvation: 6-flit packet on input 2 with only 4 credits
      $display("[TB] credit stall");
      expectGrant(5'b00100, 3'd2);
      expectXfer(3'd2, H); expectXfer(3'd2, B); expectXfer(3'd2, B);
      expectXfer(3'd2, B); expectXfer(3'd2, B); expectXfer(3'd2, T);
      t2_pkt = packTypes(H, H, H, H, H);
      applyStimulus(5'b00100, t2_pkt, 1'b0);
      applyStimulus(5'b00100, t2_pkt, 1'b0);
      t2_pkt = packTypes(H, H, B, H, H);
      repeat (3) applyStimulus(5'b00100, t2_pkt, 1'b0);
      checkOutput("stall_credit_zero", 32'(credit_cnt), 32'd0);
      applyStimulus(5'b00100, t2_pkt, 1'b0);
      checkOutput("stall_xfer_blocked", 32'(xfer), 32'd0);
      checkOutput("stall_grant_held", 32'(grant), 32'b00100);
      checkOutput("stall_not_idle", 32'(idle), 32'd0);
      applyStimulus(5'b00100, t2_pkt, 1'b1);
      checkOutput("stall_credit_one", 32'(credit_cnt), 32'd1);
      applyStimulus(5'b00100, t2_pkt, 1'b0);
      applyStimulus(5'b00100, t2_pkt, 1'b0);
      checkOutput("stall_credit_zero_again", 32'(credit_cnt), 32'd0);
      checkOutput("stall_xfer_blocked_again", 32'(xfer), 32'd0);
      t2_pkt = packTypes(H, H, T, H, H);
      applyStimulus(5'b00100, t2_pkt, 1'b1);
      applyStimulus(5'b00100, t2_pkt, 1'b0);
      checkOutput("stall_idle_after_tail", 32'(idle), 32'd1);
      applyStimulus(5'b00000, all_s, 1'b0);
      repeat (4) applyStimulus(5'b00000, all_s, 1'b1);
      checkOutput("stall_credit_restored", 32'(credit_cnt), 32'd4);

      // Credit returned while full
      $display("[TB] credit overflow");
      applyStimulus(5'b00000, all_s, 1'b1);
      checkOutput("ovf_credit_saturated", 32'(credit_cnt), 32'd4);
      checkOutput("ovf_credit_err_set", 32'(credit_err), 32'd1);
      repeat (2) applyStimulus(5'b00000, all_s, 1'b0);
      checkOutput("ovf_credit_err_sticky", 32'(credit_err), 32'd1);

      // Single-flit packet on input 4
      $display("[TB] single flit and dropped request");
      expectGrant(5'b10000, 3'd4); expectXfer(3'd4, S);
      applyStimulus(5'b10000, all_s, 1'b0);
      applyStimulus(5'b10000, all_s, 1'b0);
      checkOutput("single_idle_after", 32'(idle), 32'd1);
      checkOutput("single_credit_after", 32'(credit_cnt), 32'd3);
      applyStimulus(5'b00000, all_s, 1'b0);

      // Input 1 drops its request mid-packet
      expectGrant(5'b00010, 3'd1); expectXfer(3'd1, H);
      applyStimulus(5'b00010, packTypes(H, H, H, H, H), 1'b0);
      applyStimulus(5'b00010, packTypes(H, H, H, H, H), 1'b0);
      applyStimulus(5'b00000, packTypes(H, H, H, H, H), 1'b0);
      checkOutput("drop_grant_held", 32'(grant), 32'b00010);
      checkOutput("drop_xfer_low", 32'(xfer), 32'd0);
      checkOutput("drop_not_idle", 32'(idle), 32'd0);
      applyStimulus(5'b00000, packTypes(H, H, H, H, H), 1'b0);
      checkOutput("drop_grant_still_held", 32'(grant), 32'b00010);
      checkOutput("drop_credit", 32'(credit_cnt), 32'd2);

      // Asynchronous reset in the middle of the locked packet
      $display("[TB] asynchronous reset");
      #2 rst = 1'b0;
      #1;
      checkOutput("areset_grant", 32'(grant), 32'd0);
      checkOutput("areset_idle", 32'(idle), 32'd1);
      checkOutput("areset_credit_cnt", 32'(credit_cnt), 32'd4);
      checkOutput("areset_credit_err", 32'(credit_err), 32'd0);
      checkOutput("areset_sel", 32'(sel), 32'd0);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      expectGrant(5'b00001, 3'd0); expectXfer(3'd0, S);
      applyStimulus(5'b10001, all_s, 1'b0);
      applyStimulus(5'b10001, all_s, 1'b0);
      applyStimulus(5'b00000, all_s, 1'b0);
      checkOutput("post_reset_idle", 32'(idle), 32'd1);
      checkOutput("post_reset_credit", 32'(credit_cnt), 32'd3);

      repeat (2) applyStimulus(5'b00000, all_s, 1'b0);
      checkOutput("grant_events_all_seen", 32'(grant_exp_q.size()), 32'd0);
      checkOutput("xfer_events_all_seen", 32'(xfer_exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
